// File: rtl/ps2_reg_ctrl_dual_if.sv
// OPB IPIF register-protocol bundle between the IPIF and the dual-port
// PS/2 register controller. Bit ordering follows the IPIF: index 0 is the
// MSB of data words and chip-enable 0 selects port 0 STATUS.
interface ps2_reg_ctrl_dual_if;
    logic [0:15] Bus2IP_RegCE;
    logic [0:7]  Bus2IP_Data;
    logic        Bus2IP_RdReq;
    logic        Bus2IP_WrReq;
    logic [0:7]  IP2Bus_Data;
    logic        IP2Bus_RdAck;
    logic        IP2Bus_WrAck;
    logic        IP2Bus_Error;
    logic        IP2Bus_Retry;
    logic        IP2Bus_ToutSup;
    logic        IP2Bus_Intr1;
    logic        IP2Bus_Intr2;

    modport slave (
        input  Bus2IP_RegCE, Bus2IP_Data, Bus2IP_RdReq, Bus2IP_WrReq,
        output IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error,
               IP2Bus_Retry, IP2Bus_ToutSup, IP2Bus_Intr1, IP2Bus_Intr2
    );

    modport master (
        output Bus2IP_RegCE, Bus2IP_Data, Bus2IP_RdReq, Bus2IP_WrReq,
        input  IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error,
               IP2Bus_Retry, IP2Bus_ToutSup, IP2Bus_Intr1, IP2Bus_Intr2
    );
endinterface

// File: rtl/ps2_reg_ctrl_dual.sv
// Register controller for a dual-port PS/2 peripheral behind the OPB IPIF.
// Decodes the 16 register chip-enables (8 per port), keeps per-port
// receive byte, interrupt status/mask and transmit byte, launches transmits
// into the serial engines and drives the two interrupt lines.
// Optional build macro PS2_TX_RETRY_EN: a TXDATA write while the port is
// still transmitting is answered with IP2Bus_Retry instead of WrAck+Error.
module ps2_reg_ctrl_dual #(
    parameter int C_TX_HOLD_MAX = 8
) (
    input  logic               OPB_Clk,
    input  logic               OPB_Rst_n,
    ps2_reg_ctrl_dual_if.slave bus,
    input  logic [1:0]         rx_valid,
    input  logic [1:0]         rx_err,
    input  logic [15:0]        rx_data,
    output logic [1:0]         tx_start,
    output logic [15:0]        tx_data,
    input  logic [1:0]         tx_busy,
    input  logic [1:0]         tx_done,
    input  logic [1:0]         tx_noack
);

    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_RXDATA  = 3'd1;
    localparam logic [2:0] REG_TXDATA  = 3'd2;
    localparam logic [2:0] REG_INTSTA  = 3'd3;
    localparam logic [2:0] REG_INTMASK = 3'd4;

    localparam int               CNT_W    = $clog2(C_TX_HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_TX_HOLD_MAX - 1);

    typedef enum logic {IDLE, RESP} state_t;
    typedef enum logic [1:0] {ACT_NONE, ACT_RXCLR, ACT_WRITE} act_t;

    state_t state;
    act_t   pend_act;
    logic   pend_port;
    logic [2:0] pend_reg;
    logic [7:0] pend_wdata;

    logic [1:0]            rx_full;
    logic [1:0][7:0]       rx_byte;
    logic [1:0][7:0]       intsta;
    logic [1:0][7:0]       intmask;
    logic [1:0][7:0]       tx_byte;
    logic [1:0][CNT_W-1:0] hold_cnt;

    logic [7:0] wdata;
    logic [3:0] ce_idx;
    logic       ce_single;
    logic       sel_port;
    logic [2:0] sel_reg;
    logic [1:0] tx_active;
    logic       rd_legal;
    logic       wr_legal;
    logic       tx_blocked;
    logic [7:0] rd_value;

    logic [1:0]      rx_take;
    logic [1:0]      rx_drop;
    logic [1:0]      rx_clear;
    logic [1:0]      tx_load;
    logic [1:0]      mask_load;
    logic [1:0]      tx_fail;
    logic [1:0][7:0] sta_set;
    logic [1:0][7:0] sta_clr;

    assign tx_active = tx_start | tx_busy;
    assign wdata     = bus.Bus2IP_Data;
    assign ce_single = ($countones(bus.Bus2IP_RegCE) == 1);
    assign sel_port  = ce_idx[3];
    assign sel_reg   = ce_idx[2:0];
    assign tx_data   = tx_byte;

    assign bus.IP2Bus_ToutSup = 1'b0;

    // Locate the selected chip-enable; only meaningful when exactly one is set
    always_comb begin
        ce_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (bus.Bus2IP_RegCE[i]) ce_idx = 4'(i);
        end
    end

    // Classify the request and build the read word for the selected register
    always_comb begin
        rd_legal   = ce_single && (sel_reg == REG_STATUS || sel_reg == REG_RXDATA ||
                                   sel_reg == REG_INTSTA || sel_reg == REG_INTMASK);
        wr_legal   = ce_single && (sel_reg == REG_TXDATA || sel_reg == REG_INTSTA ||
                                   sel_reg == REG_INTMASK);
        tx_blocked = (sel_reg == REG_TXDATA) && tx_active[sel_port];
        case (sel_reg)
            REG_STATUS:  rd_value = {rx_full[sel_port], tx_active[sel_port], 6'b000000};
            REG_RXDATA:  rd_value = rx_byte[sel_port];
            REG_INTSTA:  rd_value = intsta[sel_port];
            REG_INTMASK: rd_value = intmask[sel_port];
            default:     rd_value = 8'h00;
        endcase
    end

    // Per-port event decode: receive, pending register side-effects, transmit timeout
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rx_take[p]   = rx_valid[p] & ~rx_err[p] & ~rx_full[p];
            rx_drop[p]   = rx_valid[p] & ~rx_err[p] & rx_full[p];
            rx_clear[p]  = (state == RESP) && (pend_port == 1'(p)) && (pend_act == ACT_RXCLR);
            tx_load[p]   = (state == RESP) && (pend_port == 1'(p)) && (pend_act == ACT_WRITE) &&
                           (pend_reg == REG_TXDATA);
            mask_load[p] = (state == RESP) && (pend_port == 1'(p)) && (pend_act == ACT_WRITE) &&
                           (pend_reg == REG_INTMASK);
            sta_clr[p]   = ((state == RESP) && (pend_port == 1'(p)) && (pend_act == ACT_WRITE) &&
                            (pend_reg == REG_INTSTA)) ? pend_wdata : 8'h00;
            tx_fail[p]   = tx_start[p] & ~tx_busy[p] & (hold_cnt[p] == CNT_LAST);
            sta_set[p]   = {rx_take[p], rx_err[p], rx_drop[p], tx_done[p],
                            tx_noack[p] | tx_fail[p], 3'b000};
        end
    end

    // Bus FSM: answer each request one cycle later and latch its side-effect
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state             <= IDLE;
            pend_act          <= ACT_NONE;
            pend_port         <= 1'b0;
            pend_reg          <= 3'd0;
            pend_wdata        <= 8'h00;
            bus.IP2Bus_Data   <= 8'h00;
            bus.IP2Bus_RdAck  <= 1'b0;
            bus.IP2Bus_WrAck  <= 1'b0;
            bus.IP2Bus_Error  <= 1'b0;
            bus.IP2Bus_Retry  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Bus2IP_RdReq || bus.Bus2IP_WrReq) begin
                        state      <= RESP;
                        pend_port  <= sel_port;
                        pend_reg   <= sel_reg;
                        pend_wdata <= wdata;
                        if (bus.Bus2IP_RdReq) begin
                            bus.IP2Bus_RdAck <= 1'b1;
                            bus.IP2Bus_Error <= ~rd_legal;
                            bus.IP2Bus_Data  <= rd_legal ? rd_value : 8'h00;
                            pend_act         <= (rd_legal && sel_reg == REG_RXDATA) ? ACT_RXCLR
                                                                                    : ACT_NONE;
                        end else if (!wr_legal) begin
                            bus.IP2Bus_WrAck <= 1'b1;
                            bus.IP2Bus_Error <= 1'b1;
                            pend_act         <= ACT_NONE;
                        end else if (tx_blocked) begin
`ifdef PS2_TX_RETRY_EN
                            bus.IP2Bus_Retry <= 1'b1;
`else
                            bus.IP2Bus_WrAck <= 1'b1;
                            bus.IP2Bus_Error <= 1'b1;
`endif
                            pend_act         <= ACT_NONE;
                        end else begin
                            bus.IP2Bus_WrAck <= 1'b1;
                            pend_act         <= ACT_WRITE;
                        end
                    end
                end
                RESP: begin
                    state            <= IDLE;
                    pend_act         <= ACT_NONE;
                    bus.IP2Bus_Data  <= 8'h00;
                    bus.IP2Bus_RdAck <= 1'b0;
                    bus.IP2Bus_WrAck <= 1'b0;
                    bus.IP2Bus_Error <= 1'b0;
                    bus.IP2Bus_Retry <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Per-port register file: receive capture, W1C status, mask, transmit launch/hold
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            rx_full  <= '0;
            rx_byte  <= '0;
            intsta   <= '0;
            intmask  <= '0;
            tx_byte  <= '0;
            tx_start <= '0;
            hold_cnt <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (rx_take[p]) begin
                    rx_byte[p] <= rx_data[8*p +: 8];
                    rx_full[p] <= 1'b1;
                end else if (rx_clear[p]) begin
                    rx_full[p] <= 1'b0;
                end

                // set wins over a same-cycle write-one-to-clear
                intsta[p] <= (intsta[p] & ~sta_clr[p]) | sta_set[p];

                if (mask_load[p]) intmask[p] <= pend_wdata;

                if (tx_load[p]) begin
                    tx_byte[p]  <= pend_wdata;
                    tx_start[p] <= 1'b1;
                    hold_cnt[p] <= '0;
                end else if (tx_start[p]) begin
                    if (tx_busy[p] || tx_fail[p]) tx_start[p] <= 1'b0;
                    else                          hold_cnt[p] <= hold_cnt[p] + 1'b1;
                end
            end
        end
    end

    // Interrupt lines follow the masked status one cycle later
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            bus.IP2Bus_Intr1 <= 1'b0;
            bus.IP2Bus_Intr2 <= 1'b0;
        end else begin
            bus.IP2Bus_Intr1 <= |(intsta[0] & intmask[0]);
            bus.IP2Bus_Intr2 <= |(intsta[1] & intmask[1]);
        end
    end

endmodule

// File: tb/tb_ps2_reg_ctrl_dual.sv
// Self-checking bench for ps2_reg_ctrl_dual: directed scenarios followed by
// randomized register traffic and PS/2 engine events, compared against a
// transaction-level model of the register map.
module tb_ps2_reg_ctrl_dual;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  rx_valid, rx_err, tx_start, tx_busy, tx_done, tx_noack;
    logic [15:0] rx_data, tx_data;

    ps2_reg_ctrl_dual_if bus();

    ps2_reg_ctrl_dual #(.C_TX_HOLD_MAX(8)) dut (
        .OPB_Clk   (clk),
        .OPB_Rst_n (rst_n),
        .bus       (bus),
        .rx_valid  (rx_valid),
        .rx_err    (rx_err),
        .rx_data   (rx_data),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .tx_noack  (tx_noack)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    logic [1:0] m_rx_full, m_tx_active;
    logic [7:0] m_rx_byte [2];
    logic [7:0] m_intsta  [2];
    logic [7:0] m_intmask [2];
    logic [7:0] m_txdata  [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [0:15] one(input int idx);
        logic [0:15] v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [0:15] rand_ce();
        logic [0:15] v = '0;
        int a, sel;
        sel = $urandom_range(0, 9);
        a   = $urandom_range(0, 15);
        if (sel == 0) return v;
        v[a] = 1'b1;
        if (sel == 1) v[(a + $urandom_range(1, 15)) % 16] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_rx_full   = '0;
        m_tx_active = '0;
        for (int p = 0; p < 2; p++) begin
            m_rx_byte[p] = 8'h00;
            m_intsta[p]  = 8'h00;
            m_intmask[p] = 8'h00;
            m_txdata[p]  = 8'h00;
        end
    endtask

    // expected response {RdAck,WrAck,Error,Retry} and read data, plus side-effects
    task automatic model_access(input logic wr, input logic [0:15] ce, input logic [7:0] wd,
                                output logic [3:0] ersp, output logic [7:0] erd);
        int ones = 0;
        int idx  = 0;
        int p, r;
        for (int i = 0; i < 16; i++) if (ce[i]) begin ones++; idx = i; end
        p   = idx / 8;
        r   = idx % 8;
        erd = 8'h00;
        if (!wr) begin
            if (ones != 1 || r == 2 || r > 4) ersp = 4'b1010;
            else begin
                ersp = 4'b1000;
                case (r)
                    0: erd = {m_rx_full[p], m_tx_active[p], 6'b000000};
                    1: begin erd = m_rx_byte[p]; m_rx_full[p] = 1'b0; end
                    3: erd = m_intsta[p];
                    default: erd = m_intmask[p];
                endcase
            end
        end else begin
            if (ones != 1 || r < 2 || r > 4) ersp = 4'b0110;
            else if (r == 2 && m_tx_active[p]) begin
`ifdef PS2_TX_RETRY_EN
                ersp = 4'b0001;
`else
                ersp = 4'b0110;
`endif
            end else begin
                ersp = 4'b0100;
                case (r)
                    2: begin m_txdata[p] = wd; m_tx_active[p] = 1'b1; end
                    3: m_intsta[p] = m_intsta[p] & ~wd;
                    default: m_intmask[p] = wd;
                endcase
            end
        end
    endtask

    task automatic bus_op(input logic wr, input logic [0:15] ce, input logic [7:0] wd,
                          output logic [3:0] rsp, output logic [7:0] rd);
        @(negedge clk);
        bus.Bus2IP_RegCE = ce;
        bus.Bus2IP_Data  = wd;
        bus.Bus2IP_RdReq = ~wr;
        bus.Bus2IP_WrReq = wr;
        @(negedge clk);
        rsp = {bus.IP2Bus_RdAck, bus.IP2Bus_WrAck, bus.IP2Bus_Error, bus.IP2Bus_Retry};
        rd  = bus.IP2Bus_Data;
        bus.Bus2IP_RdReq = 1'b0;
        bus.Bus2IP_WrReq = 1'b0;
        bus.Bus2IP_RegCE = '0;
        bus.Bus2IP_Data  = '0;
    endtask

    task automatic access(input string tag, input logic wr, input logic [0:15] ce,
                          input logic [7:0] wd);
        logic [3:0] rsp, ersp;
        logic [7:0] rd, erd;
        model_access(wr, ce, wd, ersp, erd);
        bus_op(wr, ce, wd, rsp, rd);
        check({tag, "/rsp"}, 32'(rsp), 32'(ersp));
        check({tag, "/data"}, 32'(rd), 32'(erd));
    endtask

    task automatic rx_pulse(input int p, input logic v, input logic e, input logic [7:0] d);
        @(negedge clk);
        rx_valid[p]       = v;
        rx_err[p]         = e;
        rx_data[8*p +: 8] = d;
        @(negedge clk);
        rx_valid = '0;
        rx_err   = '0;
        if (e) m_intsta[p] |= 8'h40;
        else if (v) begin
            if (m_rx_full[p]) m_intsta[p] |= 8'h20;
            else begin
                m_rx_byte[p] = d;
                m_rx_full[p] = 1'b1;
                m_intsta[p] |= 8'h80;
            end
        end
    endtask

    task automatic tx_evt(input int p, input logic noack);
        @(negedge clk);
        if (noack) tx_noack[p] = 1'b1;
        else       tx_done[p]  = 1'b1;
        @(negedge clk);
        tx_done  = '0;
        tx_noack = '0;
        m_intsta[p] |= noack ? 8'h08 : 8'h10;
    endtask

    task automatic check_intr(input string tag);
        settle(2);
        check({tag, "/intr1"}, 32'(bus.IP2Bus_Intr1), 32'(|(m_intsta[0] & m_intmask[0])));
        check({tag, "/intr2"}, 32'(bus.IP2Bus_Intr2), 32'(|(m_intsta[1] & m_intmask[1])));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:15] ce;
        int hi, seen, kind, p, sel;

        rst_n = 1'b0;
        rx_valid = '0; rx_err = '0; rx_data = '0;
        tx_busy = '0; tx_done = '0; tx_noack = '0;
        bus.Bus2IP_RegCE = '0; bus.Bus2IP_Data = '0;
        bus.Bus2IP_RdReq = 1'b0; bus.Bus2IP_WrReq = 1'b0;
        model_reset();

        // reset state
        settle(3);
        check("rst/outs", 32'({bus.IP2Bus_RdAck, bus.IP2Bus_WrAck, bus.IP2Bus_Error,
                               bus.IP2Bus_Retry, bus.IP2Bus_ToutSup, bus.IP2Bus_Intr1,
                               bus.IP2Bus_Intr2, tx_start}), 0);
        check("rst/rdata", 32'(bus.IP2Bus_Data), 0);
        check("rst/txdata", 32'(tx_data), 0);
        rst_n = 1'b1;
        settle(1);
        access("status0", 1'b0, one(0), 8'h00);

        // port 1 receive with interrupt
        access("mask1", 1'b1, one(12), 8'h80);
        rx_pulse(1, 1'b1, 1'b0, 8'hAA);
        check_intr("rx1");
        check("rx1/intr2_on", 32'(bus.IP2Bus_Intr2), 1);
        access("rxdata1", 1'b0, one(9), 8'h00);
        access("status1", 1'b0, one(8), 8'h00);
        access("w1c1", 1'b1, one(11), 8'h80);
        check_intr("w1c1");
        check("w1c1/intr2_off", 32'(bus.IP2Bus_Intr2), 0);

        // overrun on port 0
        rx_pulse(0, 1'b1, 1'b0, 8'h11);
        rx_pulse(0, 1'b1, 1'b0, 8'h22);
        access("ovr/rxdata", 1'b0, one(1), 8'h00);
        access("ovr/intsta", 1'b0, one(3), 8'h00);
        access("ovr/status", 1'b0, one(0), 8'h00);
        access("ovr/clr", 1'b1, one(3), 8'hFF);

        // transmit launch and busy handshake on port 0
        access("tx0", 1'b1, one(2), 8'h55);
        check("tx0/start_n1", 32'(tx_start[0]), 0);
        settle(1);
        check("tx0/start_n2", 32'(tx_start[0]), 1);
        check("tx0/data", 32'(tx_data[7:0]), 32'h55);
        tx_busy[0] = 1'b1;
        settle(1);
        check("tx0/start_drop", 32'(tx_start[0]), 0);
        access("tx0/status", 1'b0, one(0), 8'h00);
        access("tx0/blocked", 1'b1, one(2), 8'h66);
        check("tx0/data_kept", 32'(tx_data[7:0]), 32'h55);
        @(negedge clk);
        tx_busy[0] = 1'b0;
        m_tx_active[0] = 1'b0;
        tx_evt(0, 1'b0);
        access("tx0/done", 1'b0, one(3), 8'h00);
        access("tx0/clr", 1'b1, one(3), 8'h10);

        // transmit hold timeout on port 1
        access("tx1", 1'b1, one(10), 8'h3C);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_start[1]) hi++;
        end
        check("tx1/hold_cycles", 32'(hi), 8);
        m_tx_active[1] = 1'b0;
        m_intsta[1] |= 8'h08;
        check("tx1/data", 32'(tx_data[15:8]), 32'h3C);
        access("tx1/fail", 1'b0, one(11), 8'h00);
        access("tx1/clr", 1'b1, one(11), 8'hFF);

        // illegal accesses
        access("bad/ce5", 1'b0, one(5), 8'h00);
        ce = 16'h0003;
        access("bad/multi", 1'b0, ce, 8'h00);
        access("bad/none", 1'b0, '0, 8'h00);
        access("bad/wr_ro", 1'b1, one(0), 8'hFF);
        access("bad/rd_tx", 1'b0, one(2), 8'h00);
        access("bad/wr_rsv", 1'b1, one(15), 8'h12);
        access("bad/mask_kept", 1'b0, one(12), 8'h00);

        // reset during a response and during a transmit
        access("rstmid/tx", 1'b1, one(2), 8'h99);
        settle(1);
        check("rstmid/start_pre", 32'(tx_start[0]), 1);
        @(negedge clk);
        bus.Bus2IP_RegCE = one(0);
        bus.Bus2IP_RdReq = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.Bus2IP_RdReq = 1'b0;
        bus.Bus2IP_RegCE = '0;
        @(negedge clk);
        check("rstmid/rdack", 32'(bus.IP2Bus_RdAck), 0);
        check("rstmid/start", 32'(tx_start), 0);
        check("rstmid/txdata", 32'(tx_data), 0);
        settle(2);
        rst_n = 1'b1;
        model_reset();
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.IP2Bus_RdAck || bus.IP2Bus_WrAck) seen++;
        end
        check("rstmid/no_ack", 32'(seen), 0);
        access("rstmid/status", 1'b0, one(0), 8'h00);

        // randomized traffic
        for (int it = 0; it < 200; it++) begin
            kind = $urandom_range(0, 3);
            p    = $urandom_range(0, 1);
            case (kind)
                0: begin
                    sel = $urandom_range(0, 4);
                    rx_pulse(p, sel != 3, sel >= 3, 8'($urandom));
                end
                1: access("rnd/rd", 1'b0, rand_ce(), 8'($urandom));
                2: begin
                    access("rnd/wr", 1'b1, rand_ce(), 8'($urandom));
                    if (m_tx_active != 2'b00) begin
                        settle(10);
                        for (int q = 0; q < 2; q++) begin
                            if (m_tx_active[q]) begin
                                m_tx_active[q] = 1'b0;
                                m_intsta[q] |= 8'h08;
                            end
                        end
                        check("rnd/tx_start", 32'(tx_start), 0);
                        check("rnd/tx_data", 32'(tx_data), 32'({m_txdata[1], m_txdata[0]}));
                    end
                end
                default: tx_evt(p, 1'($urandom_range(0, 1)));
            endcase
            check_intr("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ps2_reg_ctrl_dual.md
# ps2_reg_ctrl_dual

IP-side register controller for the dual-port PS/2 peripheral. Sits between the OPB slave IPIF (Bus2IP_*/IP2Bus_* register protocol, 16 register chip-enables, 8-bit data) and two PS/2 serial engines. Decodes register accesses, holds per-port status, receive, transmit and interrupt registers, sequences transmit starts into each engine and generates acks, errors, retries and the two interrupt lines.

## Interface
- C_TX_HOLD_MAX, 8: cycles tx_start may stay high waiting for tx_busy; on expiry, tx_start drops and TXFAIL (INTSTA bit 3) is set.
- OPB_Clk  in  1  clock; all logic rising-edge.
- OPB_Rst_n  in  1  reset; asynchronous, active-low.
- Bus2IP_RegCE  in  [0:15]  one-hot; index = {port, reg[2:0]}; 0-7 port 0, 8-15 port 1.
- Bus2IP_Data  in  [0:7]  write data; bit 7 = LSB.
- Bus2IP_RdReq, Bus2IP_WrReq  in  1  single-cycle request strobes.
- IP2Bus_Data  out  [0:7]  read data; 0 except during RdAck.
- IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error, IP2Bus_Retry  out  1  single-cycle responses.
- IP2Bus_ToutSup  out  1  tied 0.
- IP2Bus_Intr1, IP2Bus_Intr2  out  1  port 0 / port 1 interrupt, registered.
- rx_valid  in  [1:0]  per-port byte-received pulse.
- rx_err  in  [1:0]  per-port parity/frame error pulse.
- rx_data  in  [15:0]  port p byte on [8p+7:8p].
- tx_start  out  [1:0]  per-port start request, held until tx_busy seen.
- tx_data  out  [15:0]  per-port transmit byte, stable while tx_start/tx_busy.
- tx_busy  in  [1:0]  engine transmitting.
- tx_done  in  [1:0]  transmit complete, device ACKed.
- tx_noack  in  [1:0]  transmit complete, no device ACK.

## Operation
- Registers per port (reg[2:0]): 0 STATUS RO, 1 RXDATA RO, 2 TXDATA WO, 3 INTSTA R/W1C, 4 INTMASK RW, 5-7 reserved.
- STATUS: bit 7 rx_full, bit 6 tx_active (tx_start | tx_busy), bits 5-0 zero.
- RXDATA read: returns rx byte, clears rx_full. Read while empty returns last byte, no side effect.
- rx_valid with rx_full=0: capture byte, set rx_full, INTSTA bit 7. With rx_full=1: byte dropped, INTSTA bit 5 (overrun) set.
- rx_err: INTSTA bit 6; data not captured.
- TXDATA write while tx_active=0: load tx_data, set tx_start next cycle. tx_start clears on first cycle tx_busy=1 or after C_TX_HOLD_MAX cycles.
- INTSTA bits: 7 rx, 6 rx_err, 5 overrun, 4 tx_done, 3 tx_noack/TXFAIL. Write 1 clears; same-cycle set and clear: set wins.
- IP2Bus_Intr(p) = |(INTSTA & INTMASK) of port p.
- Bad access: reserved register, write to RO, read of TXDATA, zero or multiple CE bits -> ack with IP2Bus_Error=1, no state change, read data 0.
- FSM: IDLE -> (RdReq|WrReq) RESP -> IDLE. RESP drives exactly one of RdAck/WrAck/Retry for one cycle. Requests in RESP ignored.

## Timing
- Request in cycle N -> response in cycle N+1, registered. Read data valid in same cycle as RdAck.
- Register side-effects (RXDATA clear, W1C, TXDATA load) take effect at end of cycle N+1.
- tx_start first high cycle N+2 after write request at N.
- Interrupt outputs lag INTSTA/INTMASK change by 1 cycle.
- Reset: all outputs 0, FSM IDLE, all registers 0, rx_full 0. Reset mid-transaction drops the response; mid-transmit drops tx_start; the engine is not aborted.

## Configuration
- PS2_TX_RETRY_EN defined: TXDATA write while tx_active=1 -> IP2Bus_Retry (no ack), no load.
- Undefined: same case -> WrAck with Error=1, no load.

## Test plan
- Reset release: all outputs 0; read STATUS port 0 (CE bit 0) -> RdAck at N+1, data 0x00.
- Port 1 rx_valid with byte 0xAA, INTMASK=0x80 -> Intr2=1; read RXDATA (CE 9) -> 0xAA, rx_full cleared; W1C 0x80 to INTSTA -> Intr2=0.
- Two rx_valid without read (0x11, 0x22) -> RXDATA 0x11, INTSTA=0xA0.
- Write 0x55 to port 0 TXDATA (CE 2) -> WrAck at N+1, tx_start[0] at N+2, tx_data 0x55, drops when tx_busy[0]=1; tx_done -> INTSTA bit 4.
- Second TXDATA write while busy -> Retry (macro on) or WrAck+Error (macro off); tx_busy never asserted -> tx_start low after 8 cycles, INTSTA bit 3 set.
- CE bit 5 read, and CE=0x0003 -> Error with ack, data 0x00; reset asserted during RESP -> no ack issued.
